hdmi_mdrp_access: RTL and testbench

- Runtime register-access engine for the Gowin PLL MDRP port.
- Turns single read/modify/write requests (address, mask, data) from the HDMI control logic into the MDRP INC/OPC/WDATA cycle sequence.
- Returns the read-back byte to the requester.
- Drives the PLL-init bypass inputs (MDAINC, MDOPC, MDWDI) and consumes MDRDO, so post-init PLL retuning (pixel-clock change) runs through this block.

---
 rtl/hdmi_mdrp_pkg.sv | 31 +++
 rtl/hdmi_mdrp_access.sv | 145 ++++++++++++++
 tb/tb_hdmi_mdrp_access.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hdmi_mdrp_pkg.sv
// rtl/hdmi_mdrp_pkg.sv - shared MDRP opcodes, FSM states and request record
package hdmi_mdrp_pkg;

  localparam logic [1:0] MDRP_OPC_CLR = 2'b00;
  localparam logic [1:0] MDRP_OPC_WR  = 2'b01;
  localparam logic [1:0] MDRP_OPC_RD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SEEK,
    ST_RD,
    ST_WR,
    ST_RSP
  } mdrp_state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] mask;
    logic [7:0] data;
  } mdrp_req_t;

  // Replace only the masked bits of the byte read back from the PLL.
  function automatic logic [7:0] mdrp_merge(input logic [7:0] old_byte,
                                            input logic [7:0] mask,
                                            input logic [7:0] data);
    return (old_byte & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/hdmi_mdrp_access.sv
// rtl/hdmi_mdrp_access.sv - single-request read/modify/write engine for the PLL MDRP port
module hdmi_mdrp_access
  import hdmi_mdrp_pkg::*;
#(
  parameter int         RD_LAT   = 1,
  parameter logic [7:0] ADDR_MAX = 8'h7F
) (
  input  logic       I_MD_CLK,
  input  logic       I_RST_N,
  input  logic       I_REQ_VLD,
  output logic       O_REQ_RDY,
  input  logic       I_REQ_WE,
  input  logic [7:0] I_REQ_ADDR,
  input  logic [7:0] I_REQ_MASK,
  input  logic [7:0] I_REQ_DATA,
  output logic       O_RSP_VLD,
  input  logic       I_RSP_RDY,
  output logic [7:0] O_RSP_DATA,
  output logic       O_RSP_ERR,
  output logic       O_MD_INC,
  output logic [1:0] O_MD_OPC,
  output logic [7:0] O_MD_WR_DATA,
  input  logic [7:0] I_MD_RD_DATA,
  output logic       O_BUSY
);

  // Read-wait counter is loaded with RD_LAT-1 so the last RD cycle is count zero.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  mdrp_state_t state;
  mdrp_req_t   req;
  logic [7:0]  cur_addr;   // shadow of the PLL's internal address pointer
  logic [7:0]  rd_byte;
  logic [1:0]  lat_cnt;

  // Sequencer: every output is registered alongside the state it belongs to,
  // so each branch sets the outputs for the state being entered next.
  always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state        <= ST_IDLE;
      req          <= '0;
      cur_addr     <= 8'd0;
      rd_byte      <= 8'd0;
      lat_cnt      <= 2'd0;
      O_REQ_RDY    <= 1'b0;
      O_RSP_VLD    <= 1'b0;
      O_RSP_DATA   <= 8'd0;
      O_RSP_ERR    <= 1'b0;
      O_MD_INC     <= 1'b0;
      O_MD_OPC     <= MDRP_OPC_CLR;
      O_MD_WR_DATA <= 8'd0;
      O_BUSY       <= 1'b0;
    end else begin
      O_MD_INC <= 1'b0;
      O_MD_OPC <= MDRP_OPC_RD;
      case (state)
        ST_IDLE: begin
          if (I_REQ_VLD && O_REQ_RDY) begin
            req       <= '{we: I_REQ_WE, addr: I_REQ_ADDR, mask: I_REQ_MASK, data: I_REQ_DATA};
            O_REQ_RDY <= 1'b0;
            O_BUSY    <= 1'b1;
            if (I_REQ_ADDR > ADDR_MAX) begin
              // Out-of-range: answer straight away, pointer untouched.
              state      <= ST_RSP;
              O_RSP_VLD  <= 1'b1;
              O_RSP_ERR  <= 1'b1;
              O_RSP_DATA <= 8'd0;
            end else if (I_REQ_ADDR < cur_addr) begin
              // Pointer only moves forward, so going back needs a clear first.
              state    <= ST_CLR;
              O_MD_OPC <= MDRP_OPC_CLR;
            end else begin
              state    <= ST_SEEK;
              O_MD_INC <= (cur_addr < I_REQ_ADDR);
            end
          end else begin
            O_REQ_RDY <= 1'b1;
            O_BUSY    <= 1'b0;
          end
        end

        ST_CLR: begin
          cur_addr <= 8'd0;
          state    <= ST_SEEK;
          O_MD_INC <= (req.addr != 8'd0);
        end

        ST_SEEK: begin
          if (cur_addr < req.addr) begin
            // This cycle carries an INC pulse; the PLL pointer steps on this edge.
            cur_addr <= cur_addr + 8'd1;
            O_MD_INC <= ((cur_addr + 8'd1) < req.addr);
          end else begin
            state   <= ST_RD;
            lat_cnt <= LAT_LOAD;
          end
        end

        ST_RD: begin
          if (lat_cnt == 2'd0) begin
            rd_byte <= I_MD_RD_DATA;
            if (req.we) begin
              state        <= ST_WR;
              O_MD_OPC     <= MDRP_OPC_WR;
              O_MD_WR_DATA <= mdrp_merge(I_MD_RD_DATA, req.mask, req.data);
            end else begin
              state      <= ST_RSP;
              O_RSP_VLD  <= 1'b1;
              O_RSP_ERR  <= 1'b0;
              O_RSP_DATA <= I_MD_RD_DATA;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

        ST_WR: begin
          state      <= ST_RSP;
          O_RSP_VLD  <= 1'b1;
          O_RSP_ERR  <= 1'b0;
          O_RSP_DATA <= rd_byte;
        end

        ST_RSP: begin
          // Ready is raised one cycle after the handshake, never during it.
          if (I_RSP_RDY) begin
            state     <= ST_IDLE;
            O_RSP_VLD <= 1'b0;
            O_RSP_ERR <= 1'b0;
            O_REQ_RDY <= 1'b1;
            O_BUSY    <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          O_RSP_VLD <= 1'b0;
          O_REQ_RDY <= 1'b0;
          O_BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_mdrp_access.sv
// tb/tb_hdmi_mdrp_access.sv - directed and randomized bench for hdmi_mdrp_access
module tb_hdmi_mdrp_access;

  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_vld = 1'b0;
  logic       req_rdy;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'd0;
  logic [7:0] req_mask = 8'd0;
  logic [7:0] req_data = 8'd0;
  logic       rsp_vld;
  logic       rsp_rdy = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       md_inc;
  logic [1:0] md_opc;
  logic [7:0] md_wr_data;
  logic [7:0] md_rd_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_mdrp_access #(.RD_LAT(RD_LAT), .ADDR_MAX(8'h7F)) dut (
    .I_MD_CLK     (clk),
    .I_RST_N      (rst_n),
    .I_REQ_VLD    (req_vld),
    .O_REQ_RDY    (req_rdy),
    .I_REQ_WE     (req_we),
    .I_REQ_ADDR   (req_addr),
    .I_REQ_MASK   (req_mask),
    .I_REQ_DATA   (req_data),
    .O_RSP_VLD    (rsp_vld),
    .I_RSP_RDY    (rsp_rdy),
    .O_RSP_DATA   (rsp_data),
    .O_RSP_ERR    (rsp_err),
    .O_MD_INC     (md_inc),
    .O_MD_OPC     (md_opc),
    .O_MD_WR_DATA (md_wr_data),
    .I_MD_RD_DATA (md_rd_data),
    .O_BUSY       (busy)
  );

  // PLL register file model: pointer clears on OPC=00, steps on INC, one-cycle read data.
  logic [7:0] seed_val [0:255];
  logic [7:0] mem [0:255];
  logic [7:0] pll_ptr;
  logic       loaded = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_ptr    <= 8'd0;
      md_rd_data <= 8'd0;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= seed_val[i];
        loaded <= 1'b1;
      end
    end else begin
      if (md_opc == 2'b00) pll_ptr <= 8'd0;
      else if (md_inc) pll_ptr <= pll_ptr + 8'd1;
      if (md_opc == 2'b01) mem[pll_ptr] <= md_wr_data;
      md_rd_data <= mem[pll_ptr];
    end
  end

  // Reference state: register contents and where the pointer should be.
  logic [7:0] ref_mem [0:255];
  int         ref_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] mask,
                        input logic [7:0] data, input int hold);
    int         lat, n_inc, n_clr, n_wr, exp_inc, exp_clr, exp_lat;
    logic       exp_err, got;
    logic [7:0] exp_rsp, exp_wr, wr_seen, held;
    exp_err = (addr > 8'h7F);
    exp_wr  = 8'd0;
    if (exp_err) begin
      exp_rsp = 8'd0; exp_inc = 0; exp_clr = 0; exp_lat = 1;
    end else begin
      exp_clr = (int'(addr) < ref_ptr) ? 1 : 0;
      exp_inc = (exp_clr == 1) ? int'(addr) : int'(addr) - ref_ptr;
      exp_rsp = ref_mem[addr];
      exp_lat = 2 + exp_inc + RD_LAT + exp_clr + (we ? 1 : 0);
      if (we) begin
        exp_wr = (ref_mem[addr] & ~mask) | (data & mask);
        ref_mem[addr] = exp_wr;
      end
      ref_ptr = int'(addr);
    end
    req_vld = 1'b1; req_we = we; req_addr = addr; req_mask = mask; req_data = data;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_rdy) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(got), 32'd1);
    @(negedge clk);
    req_vld = 1'b0; req_we = 1'($urandom); req_addr = 8'($urandom);
    req_mask = 8'($urandom); req_data = 8'($urandom);
    lat = 1; n_inc = 0; n_clr = 0; n_wr = 0; wr_seen = 8'd0;
    while (!rsp_vld && lat < 300) begin
      n_inc += int'(md_inc);
      if (md_opc == 2'b00) n_clr++;
      if (md_opc == 2'b01) begin n_wr++; wr_seen = md_wr_data; end
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency@%0h", addr), 32'(lat), 32'(exp_lat));
    chk($sformatf("inc_count@%0h", addr), 32'(n_inc), 32'(exp_inc));
    chk($sformatf("clr_count@%0h", addr), 32'(n_clr), 32'(exp_clr));
    chk($sformatf("wr_count@%0h", addr), 32'(n_wr), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) chk($sformatf("wr_data@%0h", addr), 32'(wr_seen), 32'(exp_wr));
    chk($sformatf("rsp_data@%0h", addr), 32'(rsp_data), 32'(exp_rsp));
    chk($sformatf("rsp_err@%0h", addr), 32'(rsp_err), 32'(exp_err));
    chk("rsp_busy_rdy", {30'd0, busy, req_rdy}, 32'b10);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_state", {rsp_vld, rsp_data, req_rdy, md_inc, md_opc},
          {1'b1, held, 1'b0, 1'b0, 2'b10});
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    chk("after_handshake", {29'd0, rsp_vld, req_rdy, busy}, 32'b010);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      seed_val[i] = 8'($urandom);
    end
    seed_val[8'h0B] = 8'h3A;
    seed_val[8'h11] = 8'hF4;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_val[i];

    // Asynchronous reset clears every output without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {rsp_vld, rsp_err, rsp_data, req_rdy, md_inc, md_opc, md_wr_data, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {29'd0, req_rdy, busy, rsp_vld}, 32'b100);
    chk("idle_opc", 32'(md_opc), 32'd2);

    do_req(1'b0, 8'h0B, 8'h00, 8'h00, 0);
    do_req(1'b1, 8'h11, 8'h07, 8'h03, 0);
    do_req(1'b0, 8'h0C, 8'h00, 8'h00, 10);
    do_req(1'b1, 8'h80, 8'hFF, 8'h55, 0);
    do_req(1'b0, 8'h11, 8'h00, 8'h00, 0);
    do_req(1'b0, 8'h11, 8'h00, 8'h00, 0);

    // Reset while seeking toward 0x40 abandons the request.
    req_vld = 1'b1; req_we = 1'b0; req_addr = 8'h40;
    for (int i = 0; i < 50; i++) begin
      if (req_rdy) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_vld = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("mid_seek_inc", 32'(md_inc), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_seek_reset", {rsp_vld, rsp_err, req_rdy, md_inc, md_opc, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(rsp_vld), 32'd0);
    end
    do_req(1'b0, 8'h05, 8'h00, 8'h00, 0);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      do_req(1'($urandom), a, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
